mem_req_arb_2to1: RTL and testbench

- Merges two requester-side memory ports (val/rdy, standard mem req/resp messages) onto one downstream memory port.
- Sits between two clients (e.g. I-side and D-side caches) and any single memory port of the test memory or a memory controller.
- Requests are granted round-robin.
- Responses are routed back to the issuing port through an in-order outstanding-request ID FIFO.
- The downstream memory must return responses in request order.

---
 rtl/mem_req_arb_2to1.sv | 152 +++++++++++++++
 tb/tb_mem_req_arb_2to1.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arb_2to1.sv
// mem_req_arb_2to1
//   Merges two requester-side val/rdy memory ports onto one downstream memory
//   port. Requests are granted round-robin. The port ID of every issued
//   request is queued in an in-order ID FIFO, and each downstream response
//   is steered back to the port at the head of that FIFO. The downstream
//   memory must therefore answer in request order.
//
// Ports
//   clk, reset                      single clock, synchronous active-high reset
//   memreq0_* / memreq1_*           client request ports (val/rdy/msg, in)
//   memresp0_* / memresp1_*         client response ports (val/rdy/msg, out)
//   mem_memreq_*                    downstream request port (out)
//   mem_memresp_*                   downstream response port (in)
//
// Request and response messages pass through unmodified. The message width
// follows the standard mem message layout: type(3) + opaque + addr + len + data.
module mem_req_arb_2to1 #(
    parameter int p_opaque_nbits    = 8,
    parameter int p_addr_nbits      = 32,
    parameter int p_data_nbits      = 32,
    parameter int p_max_outstanding = 4,
    localparam int c_len_nbits  = $clog2(p_data_nbits / 8),
    localparam int c_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits + p_data_nbits,
    localparam int c_resp_nbits = 3 + p_opaque_nbits + c_len_nbits + p_data_nbits
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    memreq0_val,
    output logic                    memreq0_rdy,
    input  logic [c_req_nbits-1:0]  memreq0_msg,

    input  logic                    memreq1_val,
    output logic                    memreq1_rdy,
    input  logic [c_req_nbits-1:0]  memreq1_msg,

    output logic                    memresp0_val,
    input  logic                    memresp0_rdy,
    output logic [c_resp_nbits-1:0] memresp0_msg,

    output logic                    memresp1_val,
    input  logic                    memresp1_rdy,
    output logic [c_resp_nbits-1:0] memresp1_msg,

    output logic                    mem_memreq_val,
    input  logic                    mem_memreq_rdy,
    output logic [c_req_nbits-1:0]  mem_memreq_msg,

    input  logic                    mem_memresp_val,
    output logic                    mem_memresp_rdy,
    input  logic [c_resp_nbits-1:0] mem_memresp_msg
);

    localparam int c_cnt_nbits = $clog2(p_max_outstanding + 1);
    localparam int c_ptr_nbits = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
    localparam logic [c_cnt_nbits-1:0] c_max_count = c_cnt_nbits'(p_max_outstanding);
    localparam logic [c_ptr_nbits-1:0] c_last_ptr  = c_ptr_nbits'(p_max_outstanding - 1);

    // prio: 0 means port 0 wins a tie
    logic                         prio_q,  prio_d;
    logic [p_max_outstanding-1:0] ids_q,   ids_d;
    logic [c_ptr_nbits-1:0]       head_q,  head_d;
    logic [c_ptr_nbits-1:0]       tail_q,  tail_d;
    logic [c_cnt_nbits-1:0]       count_q, count_d;

    logic can_issue;
    logic grant0;
    logic grant1;
    logic nonempty;
    logic head_id;
    logic req_fire;
    logic resp_fire;

    // Pointers wrap at the FIFO depth, which need not be a power of two.
    function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        can_issue = (count_q < c_max_count);
        nonempty  = (count_q != '0);
        head_id   = ids_q[head_q];

        // Request side: round-robin grant, gated only by FIFO space and the
        // downstream ready, so no response signal reaches memreqK_rdy.
        grant0 = can_issue & memreq0_val & (~memreq1_val | ~prio_q);
        grant1 = can_issue & memreq1_val & (~memreq0_val |  prio_q);

        mem_memreq_val = grant0 | grant1;
        mem_memreq_msg = grant1 ? memreq1_msg : memreq0_msg;
        memreq0_rdy    = grant0 & mem_memreq_rdy;
        memreq1_rdy    = grant1 & mem_memreq_rdy;

        // Response side: only the head port may take the response, so a
        // stalled head port blocks responses for the other port.
        memresp0_val    = mem_memresp_val & nonempty & ~head_id;
        memresp1_val    = mem_memresp_val & nonempty &  head_id;
        memresp0_msg    = mem_memresp_msg;
        memresp1_msg    = mem_memresp_msg;
        mem_memresp_rdy = nonempty & (head_id ? memresp1_rdy : memresp0_rdy);

        req_fire  = mem_memreq_val & mem_memreq_rdy;
        resp_fire = mem_memresp_val & mem_memresp_rdy;

        prio_d  = prio_q;
        ids_d   = ids_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (req_fire) begin
            ids_d[tail_q] = grant1;
            tail_d        = ptr_inc(tail_q);
            prio_d        = grant0;  // the port just served loses the next tie
        end
        if (resp_fire) begin
            head_d = ptr_inc(head_q);
        end
        case ({req_fire, resp_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ID storage is only read when count is nonzero, so it needs no reset.
    always_ff @(posedge clk) begin
        ids_q <= ids_d;
        if (reset) begin
            prio_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            prio_q  <= prio_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding has no port to go to.
    resp_without_req_a: assert property (@(posedge clk) disable iff (reset)
        !(mem_memresp_val && (count_q == '0)));

    ctrl_known_a: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({memreq0_val, memreq1_val, memresp0_rdy, memresp1_rdy,
                     mem_memreq_rdy, mem_memresp_val}));
`endif

endmodule

// File: tb/tb_mem_req_arb_2to1.sv
// tb_mem_req_arb_2to1
//   Self-checking bench for mem_req_arb_2to1: a table of per-cycle vectors
//   from reset, hand-written multi-cycle sequences, and a randomized phase
//   checked against a queue-based reference model.
module tb_mem_req_arb_2to1;

    localparam int MAXO   = 4;
    localparam int REQ_W  = 3 + 8 + 32 + 2 + 32;
    localparam int RESP_W = 3 + 8 + 2 + 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              memreq0_val, memreq0_rdy;
    logic [REQ_W-1:0]  memreq0_msg;
    logic              memreq1_val, memreq1_rdy;
    logic [REQ_W-1:0]  memreq1_msg;
    logic              memresp0_val, memresp0_rdy;
    logic [RESP_W-1:0] memresp0_msg;
    logic              memresp1_val, memresp1_rdy;
    logic [RESP_W-1:0] memresp1_msg;
    logic              mem_memreq_val, mem_memreq_rdy;
    logic [REQ_W-1:0]  mem_memreq_msg;
    logic              mem_memresp_val, mem_memresp_rdy;
    logic [RESP_W-1:0] mem_memresp_msg;

    mem_req_arb_2to1 #(
        .p_opaque_nbits(8), .p_addr_nbits(32), .p_data_nbits(32), .p_max_outstanding(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .memreq0_val(memreq0_val), .memreq0_rdy(memreq0_rdy), .memreq0_msg(memreq0_msg),
        .memreq1_val(memreq1_val), .memreq1_rdy(memreq1_rdy), .memreq1_msg(memreq1_msg),
        .memresp0_val(memresp0_val), .memresp0_rdy(memresp0_rdy), .memresp0_msg(memresp0_msg),
        .memresp1_val(memresp1_val), .memresp1_rdy(memresp1_rdy), .memresp1_msg(memresp1_msg),
        .mem_memreq_val(mem_memreq_val), .mem_memreq_rdy(mem_memreq_rdy), .mem_memreq_msg(mem_memreq_msg),
        .mem_memresp_val(mem_memresp_val), .mem_memresp_rdy(mem_memresp_rdy), .mem_memresp_msg(mem_memresp_msg)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        bit r0v, r1v, mrdy, mrv, p0r, p1r;
        bit e_q0r, e_q1r, e_mval, e_sel, e_p0v, e_p1v, e_mrr;
    } vec_t;

    task automatic chkb(input string nm, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [REQ_W-1:0] rand_req();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[REQ_W-1:0];
    endfunction

    function automatic logic [RESP_W-1:0] rand_resp();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[RESP_W-1:0];
    endfunction

    task automatic drive(input bit r0v, input bit r1v, input bit mrdy,
                         input bit mrv, input bit p0r, input bit p1r);
        memreq0_val     = r0v;
        memreq1_val     = r1v;
        mem_memreq_rdy  = mrdy;
        mem_memresp_val = mrv;
        memresp0_rdy    = p0r;
        memresp1_rdy    = p1r;
        memreq0_msg     = rand_req();
        memreq1_msg     = rand_req();
        mem_memresp_msg = rand_resp();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    vec_t tbl[10];

    initial begin
        int pr;
        int exp_q[$];

        // r0v r1v mrdy mrv p0r p1r | q0r q1r mval sel p0v p1v mrr
        tbl[0] = '{0,0,1,0,1,1, 0,0,0,0,0,0,0};
        tbl[1] = '{1,1,0,0,1,1, 0,0,1,0,0,0,0};
        tbl[2] = '{1,1,1,0,1,1, 1,0,1,0,0,0,0};
        tbl[3] = '{1,1,1,1,1,1, 0,1,1,1,1,0,1};
        tbl[4] = '{0,1,1,1,1,0, 0,1,1,1,0,1,0};
        tbl[5] = '{0,0,1,1,0,1, 0,0,0,0,0,1,1};
        tbl[6] = '{1,0,1,0,1,1, 1,0,1,0,0,0,1};
        tbl[7] = '{0,0,1,1,1,1, 0,0,0,0,0,1,1};
        tbl[8] = '{0,0,1,1,1,1, 0,0,0,0,1,0,1};
        tbl[9] = '{1,1,0,0,1,1, 0,0,1,1,0,0,0};

        reset = 1'b1;
        do_reset();

        // Table vectors, applied back to back from reset.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].r0v, tbl[i].r1v, tbl[i].mrdy, tbl[i].mrv, tbl[i].p0r, tbl[i].p1r);
            settle();
            chkb($sformatf("tbl%0d req0_rdy", i), memreq0_rdy, tbl[i].e_q0r);
            chkb($sformatf("tbl%0d req1_rdy", i), memreq1_rdy, tbl[i].e_q1r);
            chkb($sformatf("tbl%0d mreq_val", i), mem_memreq_val, tbl[i].e_mval);
            chkw($sformatf("tbl%0d mreq_msg", i), 96'(mem_memreq_msg),
                 96'(tbl[i].e_sel ? memreq1_msg : memreq0_msg));
            chkb($sformatf("tbl%0d resp0_val", i), memresp0_val, tbl[i].e_p0v);
            chkb($sformatf("tbl%0d resp1_val", i), memresp1_val, tbl[i].e_p1v);
            chkb($sformatf("tbl%0d mresp_rdy", i), mem_memresp_rdy, tbl[i].e_mrr);
            chkw($sformatf("tbl%0d resp0_msg", i), 96'(memresp0_msg), 96'(mem_memresp_msg));
            chkw($sformatf("tbl%0d resp1_msg", i), 96'(memresp1_msg), 96'(mem_memresp_msg));
            tick();
        end

        // Single read on port 0 answered the next cycle.
        do_reset();
        drive(1, 0, 1, 0, 1, 1);
        memreq0_msg[REQ_W-12 -: 32] = 32'h0000_1000;
        settle();
        chkb("single req0_rdy", memreq0_rdy, 1'b1);
        chkw("single mreq_msg", 96'(mem_memreq_msg), 96'(memreq0_msg));
        tick();
        drive(0, 0, 1, 1, 1, 1);
        settle();
        chkb("single resp0_val", memresp0_val, 1'b1);
        chkb("single resp1_val", memresp1_val, 1'b0);
        chkw("single resp0_msg", 96'(memresp0_msg), 96'(mem_memresp_msg));
        chkb("single mresp_rdy", mem_memresp_rdy, 1'b1);
        tick();
        drive(0, 0, 1, 0, 1, 1);
        settle();
        chkb("single empty_after", mem_memresp_rdy, 1'b0);
        tick();

        // Fill to the outstanding limit, then one pop frees a slot next cycle.
        do_reset();
        for (int k = 0; k < MAXO; k++) begin
            drive(1, 1, 1, 0, 1, 1);
            settle();
            chkb($sformatf("fill%0d req0_rdy", k), memreq0_rdy, (k % 2) == 0);
            chkb($sformatf("fill%0d req1_rdy", k), memreq1_rdy, (k % 2) == 1);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 1, 0, 1, 1);
            settle();
            chkb("full req0_rdy", memreq0_rdy, 1'b0);
            chkb("full req1_rdy", memreq1_rdy, 1'b0);
            chkb("full mreq_val", mem_memreq_val, 1'b0);
            tick();
        end
        drive(1, 1, 1, 1, 1, 1);
        settle();
        chkb("full pop resp0_val", memresp0_val, 1'b1);
        chkb("full pop req0_rdy", memreq0_rdy, 1'b0);
        tick();
        drive(1, 1, 1, 0, 1, 1);
        settle();
        chkb("after pop req0_rdy", memreq0_rdy, 1'b1);
        tick();
        for (int k = 0; k < MAXO; k++) begin
            drive(0, 0, 1, 1, 1, 1);
            settle();
            chkb($sformatf("drain%0d resp1_val", k), memresp1_val, (k % 2) == 0);
            chkb($sformatf("drain%0d resp0_val", k), memresp0_val, (k % 2) == 1);
            tick();
        end
        drive(0, 0, 1, 0, 1, 1);
        settle();
        chkb("drain empty", mem_memresp_rdy, 1'b0);
        tick();

        // Head-of-line blocking: port 0 stalls, port 1's response waits.
        do_reset();
        drive(1, 1, 1, 0, 1, 1);
        tick();
        drive(1, 1, 1, 0, 1, 1);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 1, 0, 1);
            settle();
            chkb("hol mresp_rdy", mem_memresp_rdy, 1'b0);
            chkb("hol resp1_val", memresp1_val, 1'b0);
            chkb("hol resp0_val", memresp0_val, 1'b1);
            tick();
        end
        drive(0, 0, 1, 1, 1, 1);
        settle();
        chkb("hol rel resp0_val", memresp0_val, 1'b1);
        chkb("hol rel mresp_rdy0", mem_memresp_rdy, 1'b1);
        tick();
        drive(0, 0, 1, 1, 1, 1);
        settle();
        chkb("hol rel resp1_val", memresp1_val, 1'b1);
        chkb("hol rel mresp_rdy1", mem_memresp_rdy, 1'b1);
        tick();
        drive(0, 0, 1, 0, 1, 1);
        settle();
        chkb("hol empty", mem_memresp_rdy, 1'b0);
        tick();

        // Simultaneous push and pop at count 2 across pointer wrap.
        do_reset();
        drive(1, 0, 1, 0, 1, 1);
        tick();
        drive(0, 1, 1, 0, 1, 1);
        tick();
        exp_q = '{0, 1};
        pr = 0;
        for (int k = 0; k < 6; k++) begin
            int g;
            drive(1, 1, 1, 1, 1, 1);
            settle();
            g = pr;
            chkb("pp resp0_val", memresp0_val, exp_q[0] == 0);
            chkb("pp resp1_val", memresp1_val, exp_q[0] == 1);
            chkb("pp mresp_rdy", mem_memresp_rdy, 1'b1);
            chkb("pp req0_rdy", memreq0_rdy, g == 0);
            chkb("pp req1_rdy", memreq1_rdy, g == 1);
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back(g);
            pr = (g == 0) ? 1 : 0;
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 1, 1, 1);
            settle();
            chkb("pp drain resp0_val", memresp0_val, exp_q[0] == 0);
            chkb("pp drain resp1_val", memresp1_val, exp_q[0] == 1);
            tick();
            void'(exp_q.pop_front());
        end
        drive(0, 0, 1, 0, 1, 1);
        settle();
        chkb("pp empty", mem_memresp_rdy, 1'b0);
        tick();

        // Reset with outstanding requests drops them and restores prio 0.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 0, 1, 1);
            tick();
        end
        drive(1, 1, 1, 0, 1, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1, 1, 0, 0, 1, 1);
        settle();
        chkb("rst mresp_rdy", mem_memresp_rdy, 1'b0);
        chkb("rst resp0_val", memresp0_val, 1'b0);
        chkb("rst resp1_val", memresp1_val, 1'b0);
        chkb("rst mreq_val", mem_memreq_val, 1'b1);
        chkw("rst prio0 msg", 96'(mem_memreq_msg), 96'(memreq0_msg));
        tick();
        drive(0, 1, 1, 0, 1, 1);
        settle();
        chkb("rst req1_rdy", memreq1_rdy, 1'b1);
        tick();

        // Randomized traffic against a queue model of outstanding ports.
        do_reset();
        exp_q.delete();
        pr = 0;
        for (int c = 0; c < 400; c++) begin
            int win;
            int dest;
            bit mrv;
            bit e_mrr;
            mrv = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), mrv,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            settle();
            win = -1;
            if (exp_q.size() < MAXO) begin
                if (memreq0_val && memreq1_val) win = pr;
                else if (memreq0_val)           win = 0;
                else if (memreq1_val)           win = 1;
            end
            dest  = (exp_q.size() > 0) ? exp_q[0] : -1;
            e_mrr = (dest == 0 && memresp0_rdy) || (dest == 1 && memresp1_rdy);
            chkb("rnd mreq_val", mem_memreq_val, win >= 0);
            chkb("rnd req0_rdy", memreq0_rdy, win == 0 && mem_memreq_rdy);
            chkb("rnd req1_rdy", memreq1_rdy, win == 1 && mem_memreq_rdy);
            chkw("rnd mreq_msg", 96'(mem_memreq_msg), 96'((win == 1) ? memreq1_msg : memreq0_msg));
            chkb("rnd resp0_val", memresp0_val, mrv && dest == 0);
            chkb("rnd resp1_val", memresp1_val, mrv && dest == 1);
            chkb("rnd mresp_rdy", mem_memresp_rdy, e_mrr);
            chkw("rnd resp_msg", 96'(dest == 1 ? memresp1_msg : memresp0_msg), 96'(mem_memresp_msg));
            tick();
            if (mrv && e_mrr) void'(exp_q.pop_front());
            if (win >= 0 && mem_memreq_rdy) begin
                exp_q.push_back(win);
                pr = (win == 0) ? 1 : 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
